// File: rtl/rv_rf_pkg.sv
// Shared widths and types for the integer register file.
package rv_rf_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xdata_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forcing, optional write-to-read bypass and
// busy masking when the producer is writing back this very cycle.
module rf_read_port #(
   parameter int XLEN   = rv_rf_pkg::XLEN,
   parameter int AW     = rv_rf_pkg::AW,
   parameter int BYPASS = 1
) (
   input  logic [AW-1:0]   rdAddr,
   input  logic [XLEN-1:0] arrayData,
   input  logic            busyBit,
   input  logic            we,
   input  logic [AW-1:0]   wrAddr,
   input  logic [XLEN-1:0] wrData,
   output logic [XLEN-1:0] rdData,
   output logic            rdBusy
);

   logic isZero;
   logic bypassHit;

   assign isZero    = (rdAddr == '0);
   assign bypassHit = (BYPASS != 0) && we && (wrAddr == rdAddr);

   // A forwarded writeback satisfies the dependency, so it also drops the stall.
   always_comb begin
      rdData = arrayData;
      rdBusy = busyBit;
      if (isZero) begin
         rdData = '0;
         rdBusy = 1'b0;
      end else if (bypassHit) begin
         rdData = wrData;
         rdBusy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with one write port and a per-register busy
// scoreboard used by decode to stall on outstanding producers.
module regfile_sb #(
   parameter int XLEN   = rv_rf_pkg::XLEN,
   parameter int NREGS  = rv_rf_pkg::NREGS,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic                we_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [XLEN-1:0]     wr_data_i,
   input  logic                issue_i,
   input  logic [AW-1:0]       issue_addr_i,
   input  logic                flush_i,
   input  logic [AW-1:0]       dbg_addr_i,
   output logic [XLEN-1:0]     dbg_data_o
);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busyNext;

   // Entry 0 is never written so it stays at its reset value of zero.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (we_i && (wr_addr_i != '0)) begin
         regs[wr_addr_i] <= wr_data_i;
      end
   end

   // Flush beats a new producer, and a new producer beats a same-cycle writeback.
   always_comb begin
      busyNext = busy;
      busyNext[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         if (flush_i) begin
            busyNext[r] = 1'b0;
         end else if (issue_i && (issue_addr_i == AW'(r))) begin
            busyNext[r] = 1'b1;
         end else if (we_i && (wr_addr_i == AW'(r))) begin
            busyNext[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rdPort
      logic [AW-1:0] portAddr;
      assign portAddr = rd_addr_i[k*AW +: AW];

      rf_read_port #(
         .XLEN   (XLEN),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_rdPort (
         .rdAddr    (portAddr),
         .arrayData (regs[portAddr]),
         .busyBit   (busy[portAddr]),
         .we        (we_i),
         .wrAddr    (wr_addr_i),
         .wrData    (wr_data_i),
         .rdData    (rd_data_o[k*XLEN +: XLEN]),
         .rdBusy    (rd_busy_o[k])
      );
   end

   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs[dbg_addr_i];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 3-port bypassing instance and a 2-port non-bypassing
// instance share stimulus; expectations are queued at drive time.
module tb_regfile_sb;
   import rv_rf_pkg::*;

   typedef struct {
      logic      we;
      reg_addr_t wa;
      xdata_t    wd;
      logic      iss;
      reg_addr_t ia;
      logic      fl;
      reg_addr_t r0, r1, r2, dbg;
      xdata_t    e0, e1, e2;
      logic [2:0] eb;
      xdata_t    edbg, n0, n1;
      logic [1:0] nb;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3*AW-1:0] rdAddr = '0;
   logic [2*AW-1:0] rdAddrNb;
   logic [3*XLEN-1:0] rdData;
   logic [2:0] rdBusy;
   logic [2*XLEN-1:0] nbData;
   logic [1:0] nbBusy;
   logic we = 1'b0;
   reg_addr_t wrAddr = '0;
   xdata_t wrData = '0;
   logic issue = 1'b0;
   reg_addr_t issueAddr = '0;
   logic flush = 1'b0;
   reg_addr_t dbgAddr = '0;
   xdata_t dbgData, nbDbg;

   int checks = 0;
   int failures = 0;
   vec_t vecs[25];
   vec_t expQ[$];

   assign rdAddrNb = rdAddr[2*AW-1:0];

   always #5 clk = ~clk;

   regfile_sb #(.NRD(3), .BYPASS(1)) dut (
      .clk_i(clk), .rst_n(rst_n), .rd_addr_i(rdAddr), .rd_data_o(rdData),
      .rd_busy_o(rdBusy), .we_i(we), .wr_addr_i(wrAddr), .wr_data_i(wrData),
      .issue_i(issue), .issue_addr_i(issueAddr), .flush_i(flush),
      .dbg_addr_i(dbgAddr), .dbg_data_o(dbgData)
   );

   regfile_sb #(.NRD(2), .BYPASS(0)) dutNb (
      .clk_i(clk), .rst_n(rst_n), .rd_addr_i(rdAddrNb), .rd_data_o(nbData),
      .rd_busy_o(nbBusy), .we_i(we), .wr_addr_i(wrAddr), .wr_data_i(wrData),
      .issue_i(issue), .issue_addr_i(issueAddr), .flush_i(flush),
      .dbg_addr_i(dbgAddr), .dbg_data_o(nbDbg)
   );

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      vec_t e;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s scoreboard empty actual=none expected=entry", tag);
         return;
      end
      e = expQ.pop_front();
      checkValue({tag, ".data0"}, rdData[0*XLEN +: XLEN], e.e0);
      checkValue({tag, ".data1"}, rdData[1*XLEN +: XLEN], e.e1);
      checkValue({tag, ".data2"}, rdData[2*XLEN +: XLEN], e.e2);
      checkValue({tag, ".busy"}, {29'd0, rdBusy}, {29'd0, e.eb});
      checkValue({tag, ".dbg"}, dbgData, e.edbg);
      checkValue({tag, ".nbData0"}, nbData[0*XLEN +: XLEN], e.n0);
      checkValue({tag, ".nbData1"}, nbData[1*XLEN +: XLEN], e.n1);
      checkValue({tag, ".nbBusy"}, {30'd0, nbBusy}, {30'd0, e.nb});
      checkValue({tag, ".nbDbg"}, nbDbg, e.edbg);
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      @(negedge clk);
      we = v.we; wrAddr = v.wa; wrData = v.wd;
      issue = v.iss; issueAddr = v.ia; flush = v.fl;
      rdAddr = {v.r2, v.r1, v.r0}; dbgAddr = v.dbg;
      expQ.push_back(v);
      #2;
      checkOutput(tag);
   endtask

   task automatic idleInputs();
      we = 1'b0; wrAddr = '0; wrData = '0;
      issue = 1'b0; issueAddr = '0; flush = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkValue({tag, ".data"}, rdData[31:0] | rdData[63:32] | rdData[95:64], 32'd0);
      checkValue({tag, ".busy"}, {29'd0, rdBusy}, 32'd0);
      checkValue({tag, ".dbg"}, dbgData, 32'd0);
      checkValue({tag, ".nbData"}, nbData[31:0] | nbData[63:32], 32'd0);
      checkValue({tag, ".nbBusy"}, {30'd0, nbBusy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //          we wa    wd            iss ia    fl r0    r1    r2    dbg   e0            e1            e2            eb      edbg          n0            n1            nb
      vecs[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[1]  = '{1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[2]  = '{1, 5'd5, 32'h12345678, 0, 5'd0, 0, 5'd5, 5'd5, 5'd0, 5'd5, 32'h12345678, 32'h12345678, 32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd5, 5'd5, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 32'h12345678, 3'b000, 32'h12345678, 32'h12345678, 32'h12345678, 2'b00};
      vecs[4]  = '{1, 5'd7, 32'h1,        0, 5'd0, 0, 5'd7, 5'd0, 5'd5, 5'd7, 32'h1,        32'h0,        32'h12345678, 3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[5]  = '{1, 5'd7, 32'hCAFEF00D, 0, 5'd0, 0, 5'd7, 5'd7, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 32'h1,        32'h1,        32'h1,        2'b00};
      vecs[6]  = '{0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd7, 5'd7, 5'd7, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 2'b00};
      vecs[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        32'h0,        3'b111, 32'h0,        32'h0,        32'h0,        2'b11};
      vecs[8]  = '{1, 5'd9, 32'hA5,       0, 5'd0, 0, 5'd9, 5'd9, 5'd0, 5'd9, 32'hA5,       32'hA5,       32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b11};
      vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hA5,       32'hA5,       32'hA5,       3'b000, 32'hA5,       32'hA5,       32'hA5,       2'b00};
      vecs[10] = '{0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hA5,       32'hA5,       32'hA5,       3'b000, 32'hA5,       32'hA5,       32'hA5,       2'b00};
      vecs[11] = '{1, 5'd9, 32'hB6,       1, 5'd9, 0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hB6,       32'hB6,       32'hB6,       3'b000, 32'hA5,       32'hA5,       32'hA5,       2'b11};
      vecs[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hB6,       32'hB6,       32'hB6,       3'b111, 32'hB6,       32'hB6,       32'hB6,       2'b11};
      vecs[13] = '{1, 5'd3, 32'h33,       1, 5'd9, 1, 5'd9, 5'd3, 5'd9, 5'd3, 32'hB6,       32'h33,       32'hB6,       3'b101, 32'h0,        32'hB6,       32'h0,        2'b01};
      vecs[14] = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd3, 5'd9, 5'd3, 32'hB6,       32'h33,       32'hB6,       3'b000, 32'h33,       32'hB6,       32'h33,       2'b00};
      vecs[15] = '{1, 5'd1, 32'h11,       0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[16] = '{1, 5'd2, 32'h22,       0, 5'd0, 0, 5'd1, 5'd0, 5'd0, 5'd1, 32'h11,       32'h0,        32'h0,        3'b000, 32'h11,       32'h11,       32'h0,        2'b00};
      vecs[17] = '{1, 5'd1, 32'hAAAA,     0, 5'd0, 0, 5'd1, 5'd2, 5'd1, 5'd1, 32'hAAAA,     32'h22,       32'hAAAA,     3'b000, 32'h11,       32'h11,       32'h22,       2'b00};
      vecs[18] = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd1, 5'd2, 5'd1, 5'd2, 32'hAAAA,     32'h22,       32'hAAAA,     3'b000, 32'h22,       32'hAAAA,     32'h22,       2'b00};
      vecs[19] = '{0, 5'd0, 32'h0,        1, 5'd4, 0, 5'd4, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};
      vecs[20] = '{0, 5'd0, 32'h0,        1, 5'd4, 0, 5'd4, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b001, 32'h0,        32'h0,        32'h0,        2'b01};
      vecs[21] = '{1, 5'd4, 32'h44,       0, 5'd0, 0, 5'd4, 5'd4, 5'd0, 5'd4, 32'h44,       32'h44,       32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b11};
      vecs[22] = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd4, 5'd4, 5'd4, 5'd4, 32'h44,       32'h44,       32'h44,       3'b000, 32'h44,       32'h44,       32'h44,       2'b00};
      vecs[23] = '{0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd1, 5'd2, 5'd9, 32'hB6,       32'hAAAA,     32'h22,       3'b000, 32'hB6,       32'hB6,       32'hAAAA,     2'b00};
      vecs[24] = '{0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd10,5'd12,5'd5, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        32'h0,        32'h0,        2'b00};

      // Outputs held at zero throughout the initial reset.
      #3;
      checkAllZero("initReset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i], $sformatf("v%0d", i));
      end

      // x9 is busy and the array is populated; reset lands mid-cycle with a write and issue pending.
      @(negedge clk);
      idleInputs();
      we = 1'b1; wrAddr = 5'd12; wrData = 32'hFFFF;
      issue = 1'b1; issueAddr = 5'd10;
      rdAddr = {5'd7, 5'd5, 5'd9}; dbgAddr = 5'd7;
      #1;
      checkValue("preReset.busy", {29'd0, rdBusy}, 32'd1);
      checkValue("preReset.data1", rdData[63:32], 32'h12345678);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("midReset");
      @(negedge clk);
      idleInputs();
      rst_n = 1'b1;
      applyStimulus(vecs[24], "postReset");

      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboardDrain actual=%0d expected=0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
